// File: rtl/cpu_mem_arb.sv
// Shared data RAM arbiter and run controller: core vs external port.
// Optional stall counter enabled by defining MEM_ARB_STALL_CNT_EN.
module cpu_mem_arb #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_run,
  output logic        running,
  input  logic [4:0]  core_ram_ctrl,
  input  logic [31:0] core_ram_addr,
  input  logic [63:0] core_ram_din,
  output logic [63:0] core_ram_dout,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [2:0]  ext_funct3,
  input  logic [31:0] ext_addr,
  input  logic [63:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [63:0] ext_rdata,
  output logic [4:0]  mem_ctrl,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_din,
  input  logic [63:0] mem_dout,
  output logic        arb_err,
  output logic [31:0] stall_cnt
);

  localparam int CW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_DRAIN,
    S_EXT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          running_q, running_d;
  logic          rvalid_q, rvalid_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          in_ext;

  assign in_ext  = (state_q == S_EXT);
  assign ext_gnt = in_ext & ext_req;

  // Next state, drain countdown and registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_HALT: begin
        if (ext_req)       state_d = S_EXT;
        else if (host_run) state_d = S_RUN;
      end
      S_RUN: begin
        if (ext_req) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
        end else if (!host_run) begin
          state_d = S_HALT;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_EXT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_EXT: begin
        if (!ext_req)
          state_d = host_run ? S_RUN : S_HALT;
      end
      default: state_d = S_HALT;
    endcase
    running_d = (state_d == S_RUN);
    rvalid_d  = ext_gnt & ~ext_we;
    rdata_d   = rvalid_q ? mem_dout : rdata_q;
    err_d     = err_q | (in_ext & core_ram_ctrl[0]);
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HALT;
      cnt_q     <= '0;
      running_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign running       = running_q;
  assign ext_rvalid    = rvalid_q;
  assign ext_rdata     = rvalid_q ? mem_dout : rdata_q;
  assign arb_err       = err_q;
  assign core_ram_dout = mem_dout;

  // RAM port mux: external owns it only in EXT
  always_comb begin
    mem_ctrl = '0;
    mem_addr = core_ram_addr;
    mem_din  = core_ram_din;
    if (in_ext) begin
      mem_addr = ext_addr;
      mem_din  = ext_wdata;
      if (ext_gnt)
        mem_ctrl = {ext_funct3, ext_we, 1'b1};
    end else if (rst_n) begin
      mem_ctrl = core_ram_ctrl;
    end
  end

`ifdef MEM_ARB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles the host wants to run but fetch is off
  always_comb begin
    stall_d = stall_q;
    if (host_run && !running_q && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_mem_arb.sv
// Directed self-checking bench for cpu_mem_arb.
// Includes a small word RAM model on the mem_* port.
module tb_cpu_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        host_run;
  logic        running;
  logic [4:0]  core_ram_ctrl;
  logic [31:0] core_ram_addr;
  logic [63:0] core_ram_din;
  logic [63:0] core_ram_dout;
  logic        ext_req;
  logic        ext_we;
  logic [2:0]  ext_funct3;
  logic [31:0] ext_addr;
  logic [63:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [63:0] ext_rdata;
  logic [4:0]  mem_ctrl;
  logic [31:0] mem_addr;
  logic [63:0] mem_din;
  logic [63:0] mem_dout;
  logic        arb_err;
  logic [31:0] stall_cnt;

  int tests;
  int fails;

  logic [63:0] ram [0:255];

  cpu_mem_arb #(.DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_run(host_run), .running(running),
    .core_ram_ctrl(core_ram_ctrl),
    .core_ram_addr(core_ram_addr),
    .core_ram_din(core_ram_din),
    .core_ram_dout(core_ram_dout),
    .ext_req(ext_req), .ext_we(ext_we),
    .ext_funct3(ext_funct3),
    .ext_addr(ext_addr),
    .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .mem_ctrl(mem_ctrl),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .arb_err(arb_err),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ctrl[0]) begin
      if (mem_ctrl[1]) ram[mem_addr[10:3]] <= mem_din;
      else mem_dout <= ram[mem_addr[10:3]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    core_ram_ctrl = '0;
    core_ram_addr = '0;
    core_ram_din  = '0;
    ext_req       = 1'b0;
    ext_we        = 1'b0;
    ext_funct3    = '0;
    ext_addr      = '0;
    ext_wdata     = '0;
  endtask

  task automatic do_reset(input logic run);
    idle_inputs();
    host_run = run;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    host_run = 1'b0;
    rst_n = 1'b0;
    core_ram_ctrl = 5'b01011;
    core_ram_addr = 32'h0000_0123;
    #1;
    tests++;
    if (running !== 1'b0) begin
      fails++; $display("FAIL rst_running got %b want 0", running);
    end
    tests++;
    if (ext_gnt !== 1'b0 || ext_rvalid !== 1'b0 || arb_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_flags got gnt=%b rv=%b err=%b want 0 0 0",
               ext_gnt, ext_rvalid, arb_err);
    end
    tests++;
    if (ext_rdata !== 64'd0 || stall_cnt !== 32'd0) begin
      fails++;
      $display("FAIL rst_data got rdata=%h stall=%0d want 0 0",
               ext_rdata, stall_cnt);
    end
    tests++;
    if (mem_ctrl !== 5'd0) begin
      fails++; $display("FAIL rst_mem_ctrl got %b want 00000", mem_ctrl);
    end
    tests++;
    if (mem_addr !== 32'h0000_0123) begin
      fails++; $display("FAIL rst_mem_addr got %h want 00000123", mem_addr);
    end
  endtask

  task automatic test_run();
    do_reset(1'b1);
    #1;
    tests++;
    if (running !== 1'b0) begin
      fails++; $display("FAIL run_first_cycle got %b want 0", running);
    end
    tick();
    tests++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL run_rise got %b want 1", running);
    end
    core_ram_ctrl = 5'b01011;
    core_ram_addr = 32'h0000_0100;
    core_ram_din  = 64'hCAFE_F00D_1234_5678;
    #1;
    tests++;
    if (mem_ctrl !== 5'b01011 || mem_addr !== 32'h100 ||
        mem_din !== 64'hCAFE_F00D_1234_5678) begin
      fails++;
      $display("FAIL core_store got ctrl=%b addr=%h din=%h want 01011 100 cafef00d12345678",
               mem_ctrl, mem_addr, mem_din);
    end
    tests++;
    if (ext_gnt !== 1'b0) begin
      fails++; $display("FAIL run_gnt got %b want 0", ext_gnt);
    end
    tick();
    core_ram_ctrl = '0;
  endtask

  task automatic test_drain_read();
    int n;
    ext_req    = 1'b1;
    ext_we     = 1'b0;
    ext_funct3 = 3'b011;
    ext_addr   = 32'h0000_0100;
    #1;
    tests++;
    if (ext_gnt !== 1'b0 || running !== 1'b1) begin
      fails++;
      $display("FAIL drain_req_cycle got gnt=%b run=%b want 0 1",
               ext_gnt, running);
    end
    tick();
    tests++;
    if (running !== 1'b0) begin
      fails++; $display("FAIL drain_running got %b want 0", running);
    end
    n = 1;
    while (ext_gnt !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 5) begin
      fails++; $display("FAIL drain_latency got %0d want 5", n);
    end
    tests++;
    if (mem_ctrl !== 5'b01101 || mem_addr !== 32'h100) begin
      fails++;
      $display("FAIL ext_read_port got ctrl=%b addr=%h want 01101 100",
               mem_ctrl, mem_addr);
    end
    tick();
    ext_req = 1'b0;
    #1;
    tests++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== 64'hCAFE_F00D_1234_5678) begin
      fails++;
      $display("FAIL drain_rdata got rv=%b data=%h want 1 cafef00d12345678",
               ext_rvalid, ext_rdata);
    end
    tick();
    tests++;
    if (ext_rvalid !== 1'b0 || running !== 1'b1 ||
        ext_rdata !== 64'hCAFE_F00D_1234_5678) begin
      fails++;
      $display("FAIL back_to_run got rv=%b run=%b data=%h want 0 1 cafef00d12345678",
               ext_rvalid, running, ext_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int g;
    host_run = 1'b0;
    tick();
    tick();
    tests++;
    if (running !== 1'b0) begin
      fails++; $display("FAIL halt_running got %b want 0", running);
    end
    g = 0;
    ext_req = 1'b1; ext_we = 1'b1; ext_funct3 = 3'b011;
    ext_addr = 32'h200; ext_wdata = 64'hAAAA_0000_0000_0001;
    #1;
    tests++;
    if (ext_gnt !== 1'b0) begin
      fails++; $display("FAIL halt_gnt got %b want 0", ext_gnt);
    end
    tick();
    tests++;
    if (ext_gnt !== 1'b1 || mem_ctrl !== 5'b01111) begin
      fails++;
      $display("FAIL b2b_first got gnt=%b ctrl=%b want 1 01111",
               ext_gnt, mem_ctrl);
    end
    if (ext_gnt === 1'b1) g++;
    tick();
    ext_addr = 32'h208; ext_wdata = 64'hBBBB_0000_0000_0002;
    #1;
    if (ext_gnt === 1'b1) g++;
    tick();
    ext_addr = 32'h210; ext_wdata = 64'hCCCC_0000_0000_0003;
    #1;
    if (ext_gnt === 1'b1) g++;
    tick();
    ext_we = 1'b0; ext_addr = 32'h200;
    #1;
    if (ext_gnt === 1'b1) g++;
    tests++;
    if (g !== 4) begin
      fails++; $display("FAIL b2b_gnt_count got %0d want 4", g);
    end
    tick();
    ext_req = 1'b0;
    #1;
    tests++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== 64'hAAAA_0000_0000_0001) begin
      fails++;
      $display("FAIL b2b_readback got rv=%b data=%h want 1 aaaa000000000001",
               ext_rvalid, ext_rdata);
    end
    tick();
    tests++;
    if (ext_rvalid !== 1'b0 || ext_rdata !== 64'hAAAA_0000_0000_0001) begin
      fails++;
      $display("FAIL b2b_hold got rv=%b data=%h want 0 aaaa000000000001",
               ext_rvalid, ext_rdata);
    end
  endtask

  task automatic test_arb_err();
    ext_req = 1'b1; ext_we = 1'b0; ext_funct3 = 3'b011;
    ext_addr = 32'h208;
    tick();
    core_ram_ctrl = 5'b01011;
    core_ram_addr = 32'h300;
    core_ram_din  = 64'h1;
    #1;
    tests++;
    if (mem_ctrl !== 5'b01101 || mem_addr !== 32'h208) begin
      fails++;
      $display("FAIL err_port got ctrl=%b addr=%h want 01101 208",
               mem_ctrl, mem_addr);
    end
    tests++;
    if (arb_err !== 1'b0) begin
      fails++; $display("FAIL err_early got %b want 0", arb_err);
    end
    tick();
    ext_req = 1'b0;
    core_ram_ctrl = '0;
    #1;
    tests++;
    if (arb_err !== 1'b1 || ext_rdata !== 64'hBBBB_0000_0000_0002) begin
      fails++;
      $display("FAIL err_set got err=%b data=%h want 1 bbbb000000000002",
               arb_err, ext_rdata);
    end
    tick();
    tick();
    tick();
    tests++;
    if (arb_err !== 1'b1) begin
      fails++; $display("FAIL err_sticky got %b want 1", arb_err);
    end
  endtask

  task automatic test_reset_mid_read();
    ext_req = 1'b1; ext_we = 1'b0; ext_funct3 = 3'b011;
    ext_addr = 32'h210;
    tick();
    tests++;
    if (ext_gnt !== 1'b1) begin
      fails++; $display("FAIL mid_gnt got %b want 1", ext_gnt);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (ext_gnt !== 1'b0 || ext_rvalid !== 1'b0 || arb_err !== 1'b0 ||
        running !== 1'b0 || mem_ctrl !== 5'd0 || ext_rdata !== 64'd0) begin
      fails++;
      $display("FAIL mid_reset got gnt=%b rv=%b err=%b run=%b ctrl=%b data=%h want all 0",
               ext_gnt, ext_rvalid, arb_err, running, mem_ctrl, ext_rdata);
    end
    tick();
    ext_req = 1'b0;
    tests++;
    if (ext_rvalid !== 1'b0) begin
      fails++; $display("FAIL mid_rvalid got %b want 0", ext_rvalid);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (ext_rvalid !== 1'b0 || ext_rdata !== 64'd0) begin
      fails++;
      $display("FAIL post_reset got rv=%b data=%h want 0 0",
               ext_rvalid, ext_rdata);
    end
  endtask

  task automatic test_stall();
    logic [31:0] s0;
    int n;
    do_reset(1'b1);
    tick();
    tick();
    s0 = stall_cnt;
    ext_req = 1'b1; ext_we = 1'b1; ext_funct3 = 3'b011;
    ext_addr = 32'h218; ext_wdata = 64'h5;
    n = 0;
    while (ext_gnt !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 5) begin
      fails++; $display("FAIL stall_gnt_wait got %0d want 5", n);
    end
    tick();
    ext_req = 1'b0;
    tick();
    tick();
    tests++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL stall_rerun got %b want 1", running);
    end
`ifdef MEM_ARB_STALL_CNT_EN
    tests++;
    if (stall_cnt !== s0 + 32'd6) begin
      fails++;
      $display("FAIL stall_cnt got %0d want %0d", stall_cnt, s0 + 32'd6);
    end
`else
    tests++;
    if (stall_cnt !== 32'd0) begin
      fails++; $display("FAIL stall_tied got %0d want 0", stall_cnt);
    end
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_run();
    test_drain_read();
    test_back_to_back();
    test_arb_err();
    test_reset_mid_read();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
